// File: rtl/b2c_req_arb_pkg.sv
`default_nettype none
// ============================================================================
// b2c_req_arb_pkg : shared types and widths for the block C request arbiter
// Rev 1.0
// ============================================================================
package b2c_req_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } b2cArbStateT;

  localparam int B2C_XFER_CNT_W = 16;
  localparam int B2C_WAIT_W     = 8;

endpackage
`default_nettype wire

// File: rtl/b2c_req_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational one-hot round-robin pick starting at last_grant+1
// Rev 1.0
// ============================================================================
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_gnt
);

  int w_best;
  int w_dist;

  // Distance from the slot after last_grant; the nearest active request wins.
  always_comb begin
    w_best  = N;
    w_dist  = 0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i + 2 * N - 1 - int'(last_grant)) % N;
      if (req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        gnt_idx = IDX_W'(i);
        any_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = any_gnt && (gnt_idx == IDX_W'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/b2c_req_arb.sv
`default_nettype none
// ============================================================================
// b2c_req_arb : round-robin arbiter + four-phase req/ack sequencer into block C
// Rev 1.0
// ============================================================================
module b2c_req_arb
  import b2c_req_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          src_vld,
  output logic [NUM_REQ-1:0]          src_rdy,
  input  logic [NUM_REQ*DATA_W-1:0]   src_data,
  output logic                        c_req,
  output logic [DATA_W-1:0]           c_data,
  input  logic                        c_ack,
  output logic [1:0]                  grant_idx,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [B2C_XFER_CNT_W-1:0]   xfer_cnt
);

  localparam logic [1:0] C_ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] C_ST_REQ     = 2'(REQ);
  localparam logic [1:0] C_ST_RELEASE = 2'(RELEASE);

  logic [1:0]                r_state;
  logic [1:0]                r_last_grant;
  logic [1:0]                r_grant_idx;
  logic [DATA_W-1:0]         r_data;
  logic [B2C_WAIT_W-1:0]     r_wait;
  logic                      r_timeout_err;
  logic [B2C_XFER_CNT_W-1:0] r_xfer_cnt;

  logic [NUM_REQ-1:0]        w_gnt;
  logic [1:0]                w_gnt_idx;
  logic                      w_any;
  logic [DATA_W-1:0]         w_sel_data;
  logic                      w_wait_hit;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (2)
  ) u_rr (
    .req        (src_vld),
    .last_grant (r_last_grant),
    .gnt        (w_gnt),
    .gnt_idx    (w_gnt_idx),
    .any_gnt    (w_any)
  );

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_sel_data = src_data[i*DATA_W +: DATA_W];
    end
  end

  // Hit on the last allowed cycle so the state is left after exactly TIMEOUT cycles.
  assign w_wait_hit = (r_wait == B2C_WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= C_ST_IDLE;
      r_last_grant  <= 2'(NUM_REQ - 1);
      r_grant_idx   <= '0;
      r_data        <= '0;
      r_wait        <= '0;
      r_timeout_err <= 1'b0;
      r_xfer_cnt    <= '0;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          r_wait <= '0;
          if (w_any) begin
            r_data       <= w_sel_data;
            r_grant_idx  <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_state      <= C_ST_REQ;
          end
        end
        C_ST_REQ: begin
          if (c_ack) begin
            r_wait  <= '0;
            r_state <= C_ST_RELEASE;
          end else if (w_wait_hit) begin
            r_wait        <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= C_ST_IDLE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        C_ST_RELEASE: begin
          if (!c_ack) begin
            r_wait     <= '0;
            r_xfer_cnt <= r_xfer_cnt + 1'b1;
            r_state    <= C_ST_IDLE;
          end else if (w_wait_hit) begin
            r_wait        <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= C_ST_IDLE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

  // Decoded from state so an asynchronous reset drops c_req at once.
  assign c_req       = (r_state == C_ST_REQ);
  assign busy        = (r_state != C_ST_IDLE);
  assign src_rdy     = (r_state == C_ST_IDLE) ? w_gnt : '0;
  assign c_data      = r_data;
  assign grant_idx   = r_grant_idx;
  assign timeout_err = r_timeout_err;
  assign xfer_cnt    = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_b2c_req_arb.sv
`default_nettype none
// ============================================================================
// tb_b2c_req_arb : directed self-checking bench for b2c_req_arb
// Rev 1.0
// ============================================================================
module tb_b2c_req_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src_vld;
  logic [1:0]  src_rdy;
  logic [15:0] src_data;
  logic        c_req;
  logic [7:0]  c_data;
  logic        c_ack;
  logic [1:0]  grant_idx;
  logic        busy;
  logic        timeout_err;
  logic [15:0] xfer_cnt;

  logic [1:0]  t_src_vld;
  logic [1:0]  t_src_rdy;
  logic [15:0] t_src_data;
  logic        t_c_req;
  logic [7:0]  t_c_data;
  logic        t_c_ack;
  logic [1:0]  t_grant_idx;
  logic        t_busy;
  logic        t_timeout_err;
  logic [15:0] t_xfer_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  b2c_req_arb dut (
    .clk         (clk),
    .rst         (rst),
    .src_vld     (src_vld),
    .src_rdy     (src_rdy),
    .src_data    (src_data),
    .c_req       (c_req),
    .c_data      (c_data),
    .c_ack       (c_ack),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .timeout_err (timeout_err),
    .xfer_cnt    (xfer_cnt)
  );

  b2c_req_arb #(.TIMEOUT(5)) dut_to (
    .clk         (clk),
    .rst         (rst),
    .src_vld     (t_src_vld),
    .src_rdy     (t_src_rdy),
    .src_data    (t_src_data),
    .c_req       (t_c_req),
    .c_data      (t_c_data),
    .c_ack       (t_c_ack),
    .grant_idx   (t_grant_idx),
    .busy        (t_busy),
    .timeout_err (t_timeout_err),
    .xfer_cnt    (t_xfer_cnt)
  );

  task automatic do_reset();
    rst        = 1'b1;
    src_vld    = 2'b00;
    src_data   = 16'h0000;
    c_ack      = 1'b0;
    t_src_vld  = 2'b00;
    t_src_data = 16'h0000;
    t_c_ack    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One full four-phase transfer on the main DUT, starting at a negedge in IDLE.
  task automatic serve(input int exp_idx, input logic [7:0] exp_data,
                       input int hold, input bit drop, input string nm);
    logic [1:0] exp_rdy;
    logic [1:0] exp_gi;
    exp_rdy = 2'b01 << exp_idx;
    exp_gi  = exp_idx[1:0];
    #1;
    n_tests++;
    if (src_rdy !== exp_rdy) begin
      n_fail++;
      $display("FAIL %s_accept: src_rdy got %b want %b", nm, src_rdy, exp_rdy);
    end
    @(negedge clk);
    if (drop) src_vld = 2'b00;
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if ({c_req, c_data, grant_idx, src_rdy} !== {1'b1, exp_data, exp_gi, 2'b00}) begin
        n_fail++;
        $display("FAIL %s_req[%0d]: c_req/c_data/grant/rdy got %b/%h/%0d/%b want 1/%h/%0d/00",
                 nm, i, c_req, c_data, grant_idx, src_rdy, exp_data, exp_gi);
      end
    end
    c_ack = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({c_req, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s_release: c_req/busy got %b/%b want 0/1", nm, c_req, busy);
    end
    c_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy got %b want 0", nm, busy);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    src_vld  = 2'b00;
    src_data = 16'hFFFF;
    c_ack    = 1'b0;
    t_src_vld = 2'b00; t_src_data = 16'h0000; t_c_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({c_req, busy, timeout_err, src_rdy, grant_idx} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req/busy/err/rdy/gi got %b%b%b%b%b want 0000000",
               c_req, busy, timeout_err, src_rdy, grant_idx);
    end
    n_tests++;
    if ({c_data, xfer_cnt} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_regs: c_data/xfer got %h/%h want 00/0000", c_data, xfer_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({src_rdy, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: rdy/busy got %b/%b want 00/0", src_rdy, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    src_data = 16'h00A5;
    src_vld  = 2'b01;
    serve(0, 8'hA5, 1, 1'b1, "single");
    n_tests++;
    if (xfer_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL single_cnt: xfer_cnt got %0d want 1", xfer_cnt);
    end
  endtask

  task automatic test_back_to_back();
    time t_start;
    do_reset();
    src_data = 16'h2211;
    src_vld  = 2'b11;
    t_start  = $time;
    serve(0, 8'h11, 1, 1'b0, "b2b0");
    serve(1, 8'h22, 1, 1'b0, "b2b1");
    serve(0, 8'h11, 1, 1'b0, "b2b2");
    serve(1, 8'h22, 1, 1'b0, "b2b3");
    src_vld = 2'b00;
    n_tests++;
    if (($time - t_start) != 160) begin
      n_fail++;
      $display("FAIL b2b_rate: elapsed got %0t want 160", $time - t_start);
    end
    n_tests++;
    if (xfer_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL b2b_cnt: xfer_cnt got %0d want 4", xfer_cnt);
    end
  endtask

  task automatic test_long_ack();
    do_reset();
    src_data = 16'h7700;
    src_vld  = 2'b10;
    serve(1, 8'h77, 10, 1'b1, "long");
    n_tests++;
    if (xfer_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL long_cnt: xfer_cnt got %0d want 1", xfer_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    t_src_data = 16'h0033;
    t_src_vld  = 2'b01;
    #1;
    n_tests++;
    if (t_src_rdy !== 2'b01) begin
      n_fail++;
      $display("FAIL to_accept: src_rdy got %b want 01", t_src_rdy);
    end
    @(negedge clk);
    t_src_vld = 2'b00;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_tests++;
      if ({t_c_req, t_timeout_err, t_c_data} !== {2'b10, 8'h33}) begin
        n_fail++;
        $display("FAIL to_wait[%0d]: req/err/data got %b/%b/%h want 1/0/33",
                 i, t_c_req, t_timeout_err, t_c_data);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({t_c_req, t_busy, t_timeout_err} !== 3'b001 || t_xfer_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL to_fire: req/busy/err/cnt got %b/%b/%b/%0d want 0/0/1/0",
               t_c_req, t_busy, t_timeout_err, t_xfer_cnt);
    end
    t_src_data = 16'h4400;
    t_src_vld  = 2'b10;
    #1;
    n_tests++;
    if (t_src_rdy !== 2'b10) begin
      n_fail++;
      $display("FAIL to_next_accept: src_rdy got %b want 10", t_src_rdy);
    end
    @(negedge clk);
    t_src_vld = 2'b00;
    n_tests++;
    if ({t_c_req, t_c_data, t_grant_idx} !== {1'b1, 8'h44, 2'd1}) begin
      n_fail++;
      $display("FAIL to_next_req: req/data/gi got %b/%h/%0d want 1/44/1",
               t_c_req, t_c_data, t_grant_idx);
    end
    t_c_ack = 1'b1;
    @(negedge clk);
    t_c_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({t_xfer_cnt, t_timeout_err, t_busy} !== {16'd1, 2'b10}) begin
      n_fail++;
      $display("FAIL to_next_done: cnt/err/busy got %0d/%b/%b want 1/1/0",
               t_xfer_cnt, t_timeout_err, t_busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_data = 16'h2211;
    src_vld  = 2'b11;
    serve(0, 8'h11, 1, 1'b0, "rmid0");
    @(negedge clk);
    n_tests++;
    if ({c_req, grant_idx} !== {1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL rmid_req: c_req/gi got %b/%0d want 1/1", c_req, grant_idx);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({c_req, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rmid_async: c_req/busy got %b/%b want 0/0", c_req, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (src_rdy !== 2'b01) begin
      n_fail++;
      $display("FAIL rmid_prio: src_rdy got %b want 01", src_rdy);
    end
    src_vld = 2'b00;
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.r_xfer_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_xfer_cnt;
    @(negedge clk);
    n_tests++;
    if (xfer_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: xfer_cnt got %h want ffff", xfer_cnt);
    end
    src_data = 16'h005A;
    src_vld  = 2'b01;
    serve(0, 8'h5A, 1, 1'b1, "wrap");
    n_tests++;
    if (xfer_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_cnt: xfer_cnt got %h want 0000", xfer_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_long_ack();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
